// File: rtl/gpu_bg_scanline_fetcher_m.sv
// rtl/gpu_bg_scanline_fetcher_m.sv - double-buffered serial background scanline fetcher
//
// Purpose: on i_start, reads the colour byte and one tile row of NTBL and PMB
// one tile at a time. Each tile's colour select, vflip and hflip are applied,
// and the tile is written into the back line buffer. The display side reads
// pixels from the front buffer, offset by that buffer's fine X scroll.
//
// Ports:
//   i_clk, i_rst          pixel clock, asynchronous active-high reset
//   i_start               1-cycle pulse: build the line i_line_y (ignored while busy)
//   i_line_y              screen line to build
//   i_scroll_x/i_scroll_y horizontal / vertical scroll captured at start
//   i_swap                1-cycle pulse: exchange front and back buffers
//   o_busy, o_done        fetch in progress / 1-cycle back-buffer-complete pulse
//   o_ntbl_re/addr, i_ntbl_rdata  nametable read port (data one cycle after re)
//   o_pmb_re/addr,  i_pmb_rdata   pattern memory read port (data one cycle after re)
//   i_pix_x               display pixel column
//   o_pix_color, o_pix_pat  registered colour / 2-bit pattern of pixel i_pix_x
module gpu_bg_scanline_fetcher_m #(
  parameter int COLS       = 32,
  parameter int ROWS       = 30,
  parameter int COLOR_W    = 3,
  parameter int COLORS_ADR = 960,
  parameter int SCROLL_EN  = 1,
  localparam int PXW       = $clog2(COLS * 8)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [7:0]         i_line_y,
  input  logic [PXW-1:0]     i_scroll_x,
  input  logic [7:0]         i_scroll_y,
  input  logic               i_swap,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_ntbl_re,
  output logic [9:0]         o_ntbl_addr,
  input  logic [7:0]         i_ntbl_rdata,
  output logic               o_pmb_re,
  output logic [8:0]         o_pmb_addr,
  input  logic [7:0]         i_pmb_rdata,
  input  logic [PXW-1:0]     i_pix_x,
  output logic [COLOR_W-1:0] o_pix_color,
  output logic [1:0]         o_pix_pat
);

  localparam int N  = COLS + ((SCROLL_EN != 0) ? 1 : 0);
  localparam int CW = $clog2(COLS);
  localparam int KW = $clog2(N);
  localparam int EW = COLOR_W + 16;

  typedef enum logic [2:0] {S_IDLE, S_COL, S_COLW, S_NT, S_P0, S_P1, S_WR} state_t;

  state_t               r_state, w_next;
  logic [7:0]           r_ey;
  logic [CW-1:0]        r_cx0;
  logic [KW-1:0]        r_k;
  logic [7:0]           r_tile, r_byte0;
  logic [COLOR_W-1:0]   r_col0, r_col1;
  logic                 r_front, r_swap_pending, r_busy, r_done;
  logic [2:0]           r_fx [2];
  logic [9:0]           r_ntbl_addr;
  logic [8:0]           r_pmb_addr;
  logic [EW-1:0]        r_buf [2][N];

  logic [PXW-1:0]       w_scroll_x;
  logic [7:0]           w_scroll_y, w_ey;
  logic [8:0]           w_ey_sum;
  logic [CW-1:0]        w_col;
  logic [2:0]           w_vy_p0, w_vy_p1, w_pix;
  logic                 w_last;
  logic [15:0]          w_line, w_line_f, w_shift;
  logic [COLOR_W-1:0]   w_colour;
  logic [PXW:0]         w_idx;
  logic [PXW-3:0]       w_tile;
  logic [EW-1:0]        w_ent;

  assign w_scroll_x = (SCROLL_EN != 0) ? i_scroll_x : '0;
  assign w_scroll_y = (SCROLL_EN != 0) ? i_scroll_y : '0;
  assign w_ey_sum   = {1'b0, i_line_y} + {1'b0, w_scroll_y};
  assign w_ey       = (w_ey_sum >= 9'(ROWS * 8)) ? 8'(w_ey_sum - 9'(ROWS * 8)) : w_ey_sum[7:0];
  assign w_col      = r_cx0 + r_k[CW-1:0];
  assign w_last     = (r_k == KW'(N - 1));
  // Vertical flip picks the mirrored row inside the tile. In P0 the tile byte is
  // still on the NTBL data bus, so the address is formed from it directly.
  assign w_vy_p0    = i_ntbl_rdata[5] ? 3'd7 - r_ey[2:0] : r_ey[2:0];
  assign w_vy_p1    = r_tile[5] ? 3'd7 - r_ey[2:0] : r_ey[2:0];
  assign w_line     = {r_byte0, i_pmb_rdata};
  assign w_colour   = r_tile[7] ? r_col1 : r_col0;

  // Horizontal flip reverses the order of the eight 2-bit pixels.
  always_comb begin
    w_line_f = w_line;
    if (r_tile[6]) begin
      for (int p = 0; p < 8; p++) begin
        w_line_f[15-2*p -: 2] = w_line[2*p+1 -: 2];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Addresses drive live only in their issuing state and hold the last issued
  // value otherwise.
  always_comb begin
    w_next      = r_state;
    o_ntbl_re   = 1'b0;
    o_pmb_re    = 1'b0;
    o_ntbl_addr = r_ntbl_addr;
    o_pmb_addr  = r_pmb_addr;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_COL;
      S_COL: begin
        o_ntbl_re   = 1'b1;
        o_ntbl_addr = 10'(COLORS_ADR);
        w_next      = S_COLW;
      end
      S_COLW: w_next = S_NT;
      S_NT: begin
        o_ntbl_re   = 1'b1;
        o_ntbl_addr = 10'({r_ey[7:3], w_col});
        w_next      = S_P0;
      end
      S_P0: begin
        o_pmb_re   = 1'b1;
        o_pmb_addr = {i_ntbl_rdata[4:0], w_vy_p0, 1'b0};
        w_next     = S_P1;
      end
      S_P1: begin
        o_pmb_re   = 1'b1;
        o_pmb_addr = {r_tile[4:0], w_vy_p1, 1'b1};
        w_next     = S_WR;
      end
      S_WR: w_next = w_last ? S_IDLE : S_NT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ey           <= '0;
      r_cx0          <= '0;
      r_k            <= '0;
      r_tile         <= '0;
      r_byte0        <= '0;
      r_col0         <= '0;
      r_col1         <= '0;
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fx[0]        <= '0;
      r_fx[1]        <= '0;
      r_ntbl_addr    <= '0;
      r_pmb_addr     <= '0;
    end else begin
      r_done      <= 1'b0;
      r_ntbl_addr <= o_ntbl_addr;
      r_pmb_addr  <= o_pmb_addr;
      if (r_state == S_IDLE) begin
        if (i_swap) r_front <= ~r_front;
        if (i_start) begin
          r_ey   <= w_ey;
          r_cx0  <= w_scroll_x[PXW-1:3];
          r_k    <= '0;
          r_busy <= 1'b1;
          // A same-cycle swap takes effect first, so the fine X belongs to the
          // buffer that is the back one after the swap.
          r_fx[~(r_front ^ i_swap)] <= w_scroll_x[2:0];
        end
      end else begin
        if (i_swap) r_swap_pending <= 1'b1;
        case (r_state)
          S_COLW: begin
            r_col0 <= i_ntbl_rdata[COLOR_W-1:0];
            r_col1 <= i_ntbl_rdata[2*COLOR_W-1:COLOR_W];
          end
          S_P0: r_tile  <= i_ntbl_rdata;
          S_P1: r_byte0 <= i_pmb_rdata;
          S_WR: begin
            r_k <= r_k + 1'b1;
            if (w_last) begin
              r_busy         <= 1'b0;
              r_done         <= 1'b1;
              r_swap_pending <= 1'b0;
              if (r_swap_pending || i_swap) r_front <= ~r_front;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == S_WR) r_buf[~r_front][r_k] <= {w_colour, w_line_f};
  end

  assign w_idx   = {1'b0, i_pix_x} + {{(PXW-2){1'b0}}, r_fx[r_front]};
  assign w_tile  = w_idx[PXW:3];
  assign w_pix   = w_idx[2:0];
  assign w_ent   = r_buf[r_front][w_tile];
  assign w_shift = w_ent[15:0] << {w_pix, 1'b0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_color <= '0;
      o_pix_pat   <= '0;
    end else begin
      o_pix_color <= w_ent[EW-1:16];
      o_pix_pat   <= w_shift[15:14];
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_gpu_bg_scanline_fetcher_m.sv
// tb/tb_gpu_bg_scanline_fetcher_m.sv - directed self-checking bench for gpu_bg_scanline_fetcher_m
module tb_gpu_bg_scanline_fetcher_m;

  localparam int N_TILES = 33;
  localparam int FETCH_CYC = 2 + 4 * N_TILES;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, swap = 1'b0;
  logic [7:0] line_y = '0, scroll_x = '0, scroll_y = '0, pix_x = '0;
  logic       busy, done, ntbl_re, pmb_re;
  logic [9:0] ntbl_addr;
  logic [8:0] pmb_addr;
  logic [7:0] ntbl_rdata = '0, pmb_rdata = '0;
  logic [2:0] pix_color;
  logic [1:0] pix_pat;

  logic [7:0] ntbl [1024];
  logic [7:0] pmb  [512];

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ntbl_re) ntbl_rdata <= ntbl[ntbl_addr];
    if (pmb_re)  pmb_rdata  <= pmb[pmb_addr];
  end

  gpu_bg_scanline_fetcher_m #(
    .COLS(32), .ROWS(30), .COLOR_W(3), .COLORS_ADR(960), .SCROLL_EN(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_line_y(line_y),
    .i_scroll_x(scroll_x), .i_scroll_y(scroll_y), .i_swap(swap),
    .o_busy(busy), .o_done(done),
    .o_ntbl_re(ntbl_re), .o_ntbl_addr(ntbl_addr), .i_ntbl_rdata(ntbl_rdata),
    .o_pmb_re(pmb_re), .o_pmb_addr(pmb_addr), .i_pmb_rdata(pmb_rdata),
    .i_pix_x(pix_x), .o_pix_color(pix_color), .o_pix_pat(pix_pat)
  );

  // Reference pixel computed from the bench's own memories.
  function automatic void exp_pix(input int ly, input int sx, input int sy, input int x,
                                  output logic [1:0] pat, output logic [2:0] col);
    int ey, idx, k, p, c, row, a, pp;
    logic [7:0]  t, cb;
    logic [15:0] ln;
    ey = ly + sy;
    if (ey >= 240) ey = ey - 240;
    idx = x + (sx % 8);
    k = idx / 8;
    p = idx % 8;
    c = ((sx / 8) + k) % 32;
    t = ntbl[(ey / 8) * 32 + c];
    row = t[5] ? 7 - (ey % 8) : ey % 8;
    a = int'(t[4:0]) * 16 + row * 2;
    ln = {pmb[a], pmb[a + 1]};
    pp = t[6] ? 7 - p : p;
    pat = ln[15 - 2 * pp -: 2];
    cb = ntbl[960];
    col = t[7] ? cb[5:3] : cb[2:0];
  endfunction

  task automatic read_pix(input int x, output logic [1:0] pat, output logic [2:0] col);
    @(negedge clk);
    pix_x = 8'(x);
    @(negedge clk);
    pat = pix_pat;
    col = pix_color;
  endtask

  task automatic pulse_swap();
    @(negedge clk);
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
  endtask

  // Starts a fetch and counts edges from the capture edge to the edge raising done.
  task automatic build_line(input int ly, input int sx, input int sy,
                            input int swap_at, input int start_at, input int sample_at,
                            output int cycles, output logic busy1,
                            output logic [9:0] nt_first, output logic [8:0] pmb_first,
                            output logic [1:0] s_pat);
    int c, nt_cnt;
    bit got_pmb;
    @(negedge clk);
    line_y = 8'(ly); scroll_x = 8'(sx); scroll_y = 8'(sy); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    c = 0; nt_cnt = 0; got_pmb = 0; cycles = -1;
    nt_first = '0; pmb_first = '0; s_pat = '0;
    while (c < 400) begin
      if (ntbl_re) begin
        nt_cnt++;
        if (nt_cnt == 2) nt_first = ntbl_addr;
      end
      if (pmb_re && !got_pmb) begin
        got_pmb = 1;
        pmb_first = pmb_addr;
      end
      if (c == sample_at) s_pat = pix_pat;
      swap  = (swap_at >= 0) && (c == swap_at || c == swap_at + 10);
      start = (c == start_at);
      @(posedge clk); #1;
      c++;
      if (done) begin
        cycles = c;
        break;
      end
    end
    swap = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_run++; if ({ntbl_re, pmb_re} !== 2'b00) begin n_fail++; $display("FAIL reset_re: got %b want 00", {ntbl_re, pmb_re}); end
    n_run++; if ({ntbl_addr, pmb_addr} !== 19'd0) begin n_fail++; $display("FAIL reset_addr: got %h/%h want 0/0", ntbl_addr, pmb_addr); end
    n_run++; if ({pix_color, pix_pat} !== 5'd0) begin n_fail++; $display("FAIL reset_pix: got %0d/%0d want 0/0", pix_color, pix_pat); end
    rst = 1'b0;
  endtask

  task automatic test_basic_line();
    int cyc; logic b1; logic [9:0] nf; logic [8:0] pf; logic [1:0] sp, pat, ep; logic [2:0] col, ec;
    int bad;
    build_line(0, 0, 0, -1, -1, -1, cyc, b1, nf, pf, sp);
    n_run++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_start: got %0b want 1", b1); end
    n_run++; if (cyc !== FETCH_CYC) begin n_fail++; $display("FAIL basic_done_latency: got %0d want %0d", cyc, FETCH_CYC); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %0b want 0", busy); end
    @(posedge clk); #1;
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b want 0", done); end
    pulse_swap();
    bad = 0;
    for (int x = 0; x < 256; x++) begin
      read_pix(x, pat, col);
      exp_pix(0, 0, 0, x, ep, ec);
      n_run++;
      if (pat !== ep || col !== ec) begin
        n_fail++; bad++;
        $display("FAIL basic_pix x=%0d: got pat %0d col %0d want pat %0d col %0d", x, pat, col, ep, ec);
      end
    end
  endtask

  task automatic test_flip_colour();
    int cyc; logic b1; logic [9:0] nf; logic [8:0] pf; logic [1:0] sp, pat; logic [2:0] col;
    ntbl[0] = 8'h60;
    ntbl[1] = 8'h81;
    pmb[8]  = 8'h1B;
    pmb[9]  = 8'h27;
    build_line(3, 0, 0, -1, -1, -1, cyc, b1, nf, pf, sp);
    n_run++; if (cyc !== FETCH_CYC) begin n_fail++; $display("FAIL flip_done_latency: got %0d want %0d", cyc, FETCH_CYC); end
    n_run++; if (pf !== 9'd8) begin n_fail++; $display("FAIL flip_vflip_addr: got %0d want 8", pf); end
    pulse_swap();
    read_pix(0, pat, col);
    n_run++; if (pat !== 2'd3) begin n_fail++; $display("FAIL flip_hflip_pix0: got %0d want 3", pat); end
    n_run++; if (col !== 3'd4) begin n_fail++; $display("FAIL colour0_select: got %0d want 4", col); end
    read_pix(7, pat, col);
    n_run++; if (pat !== 2'd0) begin n_fail++; $display("FAIL flip_hflip_pix7: got %0d want 0", pat); end
    read_pix(8, pat, col);
    n_run++; if (col !== 3'd5) begin n_fail++; $display("FAIL colour1_select: got %0d want 5", col); end
  endtask

  task automatic test_scroll();
    int cyc; logic b1; logic [9:0] nf; logic [8:0] pf; logic [1:0] sp, pat, ep; logic [2:0] col, ec;
    pmb[28] = 8'h4E;
    build_line(10, 8'h0B, 236, -1, -1, -1, cyc, b1, nf, pf, sp);
    n_run++; if (cyc !== FETCH_CYC) begin n_fail++; $display("FAIL scroll_done_latency: got %0d want %0d", cyc, FETCH_CYC); end
    n_run++; if (nf !== 10'd1) begin n_fail++; $display("FAIL scroll_first_column: got %0d want 1", nf); end
    pulse_swap();
    read_pix(0, pat, col);
    n_run++; if (pat !== 2'd2 || col !== 3'd5) begin n_fail++; $display("FAIL scroll_pix0: got pat %0d col %0d want pat 2 col 5", pat, col); end
    for (int x = 0; x < 256; x++) begin
      read_pix(x, pat, col);
      exp_pix(10, 8'h0B, 236, x, ep, ec);
      n_run++;
      if (pat !== ep || col !== ec) begin
        n_fail++;
        $display("FAIL scroll_pix x=%0d: got pat %0d col %0d want pat %0d col %0d", x, pat, col, ep, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, extra; logic b1; logic [9:0] nf; logic [8:0] pf; logic [1:0] sp;
    pmb[15] = 8'h01;
    @(negedge clk);
    pix_x = 8'd0;
    build_line(0, 0, 0, 20, 40, 60, cyc, b1, nf, pf, sp);
    n_run++; if (cyc !== FETCH_CYC) begin n_fail++; $display("FAIL b2b_done_latency: got %0d want %0d", cyc, FETCH_CYC); end
    n_run++; if (sp !== 2'd2) begin n_fail++; $display("FAIL b2b_front_held: got %0d want 2", sp); end
    @(posedge clk); #1;
    n_run++; if (pix_pat !== 2'd1) begin n_fail++; $display("FAIL b2b_swap_at_done: got %0d want 1", pix_pat); end
    extra = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_run++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_done: got %0d pulses want 0", extra); end
  endtask

  task automatic test_reset_mid_fetch();
    int c, cyc, dn; logic b1; logic [9:0] nf; logic [8:0] pf; logic [1:0] sp, pat, ep; logic [2:0] col, ec;
    @(negedge clk);
    line_y = 8'd0; scroll_x = 8'd0; scroll_y = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!(pmb_re && pmb_addr[0]) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    n_run++; if (c >= 200) begin n_fail++; $display("FAIL rstmid_reach_p1: got timeout want P1"); end
    rst = 1'b1;
    #1;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    n_run++; if ({ntbl_re, pmb_re} !== 2'b00) begin n_fail++; $display("FAIL rstmid_re: got %b want 00", {ntbl_re, pmb_re}); end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    n_run++; if (dn !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dn); end
    build_line(0, 0, 0, -1, -1, -1, cyc, b1, nf, pf, sp);
    n_run++; if (cyc !== FETCH_CYC) begin n_fail++; $display("FAIL rstmid_rebuild_latency: got %0d want %0d", cyc, FETCH_CYC); end
    pulse_swap();
    for (int x = 0; x < 256; x += 5) begin
      read_pix(x, pat, col);
      exp_pix(0, 0, 0, x, ep, ec);
      n_run++;
      if (pat !== ep || col !== ec) begin
        n_fail++;
        $display("FAIL rstmid_pix x=%0d: got pat %0d col %0d want pat %0d col %0d", x, pat, col, ep, ec);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ntbl[i] = 8'(i & 31);
    ntbl[960] = 8'h2C;
    for (int i = 0; i < 512; i++) pmb[i] = 8'((i * 37 + 11) & 255);
    repeat (3) @(posedge clk);
    test_reset();
    test_basic_line();
    test_flip_colour();
    test_scroll();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
